// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter granting two requesters one-at-a-time access to a single-port data memory.
// Misaligned or illegal accesses are answered with err without touching memory.
module dmem_arbiter #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_we,
    input  logic [DM_ADDRESS-1:0] req0_addr,
    input  logic [DATA_W-1:0]     req0_wdata,
    input  logic [2:0]            req0_funct3,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_we,
    input  logic [DM_ADDRESS-1:0] req1_addr,
    input  logic [DATA_W-1:0]     req1_wdata,
    input  logic [2:0]            req1_funct3,
    output logic                  rsp0_valid,
    output logic [DATA_W-1:0]     rsp0_rdata,
    output logic                  rsp0_err,
    output logic                  rsp1_valid,
    output logic [DATA_W-1:0]     rsp1_rdata,
    output logic                  rsp1_err,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic [DM_ADDRESS-1:0] a,
    output logic [DATA_W-1:0]     wd,
    output logic [2:0]            Funct3,
    input  logic [DATA_W-1:0]     rd
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t                state_q;
    logic                  we_q, idx_q, last_q, err_q;
    logic [DM_ADDRESS-1:0] addr_q;
    logic [DATA_W-1:0]     wdata_q, rdata_q;
    logic [2:0]            f3_q;
    logic                  gnt, hs, sel_we, legal, acc, rsp;
    logic [DM_ADDRESS-1:0] sel_addr;
    logic [DATA_W-1:0]     sel_wdata;
    logic [2:0]            sel_f3;
    always_comb begin
        // last_q holds the previous winner; a tie goes to the other requester
        gnt        = (req0_valid && req1_valid) ? !last_q : req1_valid;
        req0_ready = state_q == IDLE && req0_valid && !gnt;
        req1_ready = state_q == IDLE && req1_valid && gnt;
        hs         = req0_ready || req1_ready;
        sel_we     = gnt ? req1_we     : req0_we;
        sel_addr   = gnt ? req1_addr   : req0_addr;
        sel_wdata  = gnt ? req1_wdata  : req0_wdata;
        sel_f3     = gnt ? req1_funct3 : req0_funct3;
        legal      = sel_f3 == 3'b000
                  || (sel_f3 == 3'b001 && !sel_addr[0])
                  || (sel_f3 == 3'b010 && sel_addr[1:0] == 2'b00)
                  || (sel_f3 == 3'b100 && !sel_we);
        acc        = state_q == ACCESS;
        rsp        = state_q == RESP;
        MemRead    = acc && !we_q;
        MemWrite   = acc && we_q;
        a          = acc ? addr_q  : '0;
        wd         = acc ? wdata_q : '0;
        Funct3     = acc ? f3_q    : '0;
        rsp0_valid = rsp && !idx_q;
        rsp1_valid = rsp && idx_q;
        rsp0_rdata = rsp0_valid ? rdata_q : '0;
        rsp1_rdata = rsp1_valid ? rdata_q : '0;
        rsp0_err   = rsp0_valid && err_q;
        rsp1_err   = rsp1_valid && err_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            idx_q   <= 1'b0;
            last_q  <= 1'b1;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (hs) begin
                    we_q    <= sel_we;
                    addr_q  <= sel_addr;
                    wdata_q <= sel_wdata;
                    f3_q    <= sel_f3;
                    idx_q   <= gnt;
                    last_q  <= gnt;
                    err_q   <= !legal;
                    rdata_q <= '0;
                    state_q <= legal ? ACCESS : RESP;
                end
                ACCESS: begin
                    rdata_q <= we_q ? '0 : rd;
                    state_q <= RESP;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter DM_ADDRESS, default 9, data-memory byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have, for each requester n in {0,1}, these ports: reqn_valid in 1 request present; reqn_ready out 1 request accepted; reqn_we in 1 store=1, load=0; reqn_addr in DM_ADDRESS byte address; reqn_wdata in DATA_W store data; reqn_funct3 in 3 access size/sign code.
REQ-006 SHALL have, for each requester n, these response ports: rspn_valid out 1 response strobe; rspn_rdata out DATA_W load result; rspn_err out 1 access rejected.
REQ-007 SHALL have memory-side ports: MemRead out 1; MemWrite out 1; a out DM_ADDRESS; wd out DATA_W; Funct3 out 3; rd in DATA_W, read data valid in the same cycle as MemRead.

Function
REQ-008 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-009 In IDLE, SHALL grant one valid requester: if only one is valid, grant it; if both are valid, grant the one not granted last (round-robin pointer).
REQ-010 SHALL assert reqn_ready combinationally only in IDLE and only for the granted requester; the handshake is reqn_valid && reqn_ready.
REQ-011 On handshake, SHALL latch we/addr/wdata/funct3 and the grant index, update the round-robin pointer to the winner, and move to ACCESS.
REQ-012 On a rejected request, SHALL move directly IDLE->RESP, drive no memory strobe, and set err.
REQ-013 A load SHALL be rejected when funct3 is not in {000,001,010,100}, or is 001 with addr[0]=1, or is 010 with addr[1:0]!=00.
REQ-014 A store SHALL be rejected when funct3 is not in {000,001,010}, or on the same halfword/word misalignment rules as loads.
REQ-015 In ACCESS, for exactly one cycle, SHALL drive from latched fields: a=addr, wd=wdata, Funct3=funct3, MemRead=!we, MemWrite=we.
REQ-016 In ACCESS, SHALL capture rd into the response register for loads and capture 0 for stores, then move to RESP.
REQ-017 Outside ACCESS, SHALL hold MemRead=MemWrite=0 and a, wd, Funct3 at 0.
REQ-018 In RESP, for one cycle, SHALL assert rspn_valid only for the latched index, with rspn_rdata = the response register (0 on err or store) and rspn_err per REQ-012..014; the FSM then returns to IDLE.
REQ-019 Accepted latency SHALL be 2 cycles from handshake to rsp_valid (handshake edge -> ACCESS -> RESP); rejected latency SHALL be 1 cycle; throughput SHALL be at most one request per 3 cycles (per 2 for rejected).
REQ-020 SHALL drive rsp outputs for the non-selected requester, and all rsp outputs outside RESP, to 0.
REQ-021 SHALL ignore reqn_valid changes outside IDLE; a requester keeps valid and fields stable until ready.
REQ-022 When both requesters are valid continuously, grants SHALL strictly alternate 0,1,0,1...
REQ-023 A request arriving while the FSM is in RESP SHALL not be granted before the following IDLE cycle.

Reset
REQ-024 On reset assertion, SHALL immediately (asynchronously) enter IDLE, clear all outputs to 0, clear latched fields and the response register, and set the round-robin pointer so requester 0 wins the first tie.
REQ-025 Reset during ACCESS or RESP SHALL drop the in-flight request with no response and no further memory strobe; an already-issued MemWrite cycle is not undone.
REQ-026 After reset deassertion, the first grant SHALL be possible on the first rising edge.

Verification
REQ-027 Single load: req0 LW addr=0x010, rd=0xDEADBEEF during ACCESS -> MemRead=1, a=0x010, Funct3=010 for one cycle; rsp0_valid=1, rdata=0xDEADBEEF, err=0 two cycles after handshake.
REQ-028 Contention: req0 and req1 valid simultaneously from reset, held -> grants 0,1,0,1 on every third cycle; rsp1_valid never coincides with rsp0_valid.
REQ-029 Store: req1 SB addr=0x003 wdata=0x000000AA -> MemWrite=1, a=0x003, wd=0xAA, Funct3=000 for one cycle; rsp1_valid=1, rdata=0, err=0.
REQ-030 Misaligned: req0 LW addr=0x002 -> no MemRead/MemWrite; rsp0_valid=1, err=1, rdata=0 one cycle after handshake; req0 LH addr=0x001 -> same result.
REQ-031 Illegal funct3: req1 store funct3=100 -> rsp1_err=1 and no MemWrite.
REQ-032 Reset in ACCESS: assert reset mid-cycle during a load's ACCESS -> MemRead drops immediately and no rsp_valid follows; after release, a pending req1 and req0 tie -> req0 granted first.
